// File: rtl/regfile_defs.sv
// regfile_defs
// Shared constants for the regfile_nport slice: default geometry, the
// bytes-per-word helper and the value every entry takes on reset.
// Optional feature macro used by this slice: REGFILE_NPORT_BYPASS_EN.
package regfile_defs;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_ADDR_BITS = 5;
    localparam int DEF_NREAD     = 2;
    localparam int DEF_ZERO_REG  = 1;

    localparam int BYTES = DEF_WIDTH / 8;

    // Every storage bit clears to this value on reset.
    localparam logic RESET_BIT = 1'b0;

    function automatic int bytes_of(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/regfile_readport.sv
// regfile_readport
// One combinational read port of regfile_nport: selects an entry from the
// storage array, optionally merges an in-flight write (REGFILE_NPORT_BYPASS_EN)
// and forces entry 0 to read zero when ZERO_REG is set.
// Ports:
//   raddr_i    read address
//   mem_i      whole storage array
//   fwd_en_i   write in progress this cycle (bypass build only)
//   waddr_i    write address            (bypass build only)
//   wdata_i    write data               (bypass build only)
//   wbyteen_i  write byte mask          (bypass build only)
//   rdata_o    read data
module regfile_readport
    import regfile_defs::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int ZERO_REG  = DEF_ZERO_REG
) (
    input  logic [ADDR_BITS-1:0] raddr_i,
    input  logic [WIDTH-1:0]     mem_i [2**ADDR_BITS],
`ifdef REGFILE_NPORT_BYPASS_EN
    input  logic                 fwd_en_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic [WIDTH/8-1:0]   wbyteen_i,
`endif
    output logic [WIDTH-1:0]     rdata_o
);

    localparam int NBYTES = bytes_of(WIDTH);

    logic [WIDTH-1:0] rd;

    always_comb begin
        rd = mem_i[raddr_i];
`ifdef REGFILE_NPORT_BYPASS_EN
        // Write-first: bytes being written this cycle replace the stored ones.
        if (fwd_en_i && (raddr_i == waddr_i)) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wbyteen_i[b]) begin
                    rd[b*8 +: 8] = wdata_i[b*8 +: 8];
                end
            end
        end
`endif
        // Last so that a bypassed write to entry 0 can never leak through.
        if ((ZERO_REG != 0) && (raddr_i == '0)) begin
            rd = '0;
        end
        rdata_o = rd;
    end

endmodule

// File: rtl/regfile_nport.sv
// regfile_nport
// 2^ADDR_BITS x WIDTH register file with NREAD combinational read ports,
// one byte-masked clocked write port and an optional hardwired-zero entry 0.
// Compile-time option: REGFILE_NPORT_BYPASS_EN enables write-to-read
// forwarding (write-first); without it reads return the stored value.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset, clears all entries
//   wrenable_i write strobe
//   waddr_i    write address
//   wdata_i    write data
//   wbyteen_i  per-byte write mask, bit i covers wdata_i[8i+7:8i]
//   raddr_i    packed read addresses, port k at [k*ADDR_BITS +: ADDR_BITS]
//   rdata_o    packed read data, port k at [k*WIDTH +: WIDTH]
module regfile_nport
    import regfile_defs::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int NREAD     = DEF_NREAD,
    parameter int ZERO_REG  = DEF_ZERO_REG
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wrenable_i,
    input  logic [ADDR_BITS-1:0]       waddr_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic [WIDTH/8-1:0]         wbyteen_i,
    input  logic [NREAD*ADDR_BITS-1:0] raddr_i,
    output logic [NREAD*WIDTH-1:0]     rdata_o
);

    localparam int DEPTH  = 2**ADDR_BITS;
    localparam int NBYTES = bytes_of(WIDTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_ok;

    // Writes to entry 0 are discarded outright when it is hardwired to zero,
    // so its flops never leave the reset value.
    assign wr_ok = wrenable_i && !((ZERO_REG != 0) && (waddr_i == '0));

    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wbyteen_i[b]) begin
                    mem_d[waddr_i][b*8 +: 8] = wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Reset has priority, so a write on an edge that coincides with reset is lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= {WIDTH{RESET_BIT}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

`ifdef REGFILE_NPORT_BYPASS_EN
    logic fwd_en;
    assign fwd_en = wr_ok && !rst_i;
`endif

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        regfile_readport #(
            .WIDTH     (WIDTH),
            .ADDR_BITS (ADDR_BITS),
            .ZERO_REG  (ZERO_REG)
        ) u_readport (
            .raddr_i   (raddr_i[k*ADDR_BITS +: ADDR_BITS]),
            .mem_i     (mem_q),
`ifdef REGFILE_NPORT_BYPASS_EN
            .fwd_en_i  (fwd_en),
            .waddr_i   (waddr_i),
            .wdata_i   (wdata_i),
            .wbyteen_i (wbyteen_i),
`endif
            .rdata_o   (rdata_o[k*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_regfile_nport.sv
// tb_regfile_nport
// Drives two register files (entry 0 hardwired to zero, and entry 0 as plain
// storage) with identical stimulus; expected read values are queued when a
// step is driven and compared when the outputs are sampled.
module tb_regfile_nport;

`ifdef REGFILE_NPORT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        wrenable;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbyteen;
    logic [9:0]  raddr;
    logic [63:0] rdata_z;
    logic [63:0] rdata_n;

    regfile_nport #(.WIDTH(32), .ADDR_BITS(5), .NREAD(2), .ZERO_REG(1)) dut_z (
        .clk_i(clk), .rst_i(rst), .wrenable_i(wrenable), .waddr_i(waddr),
        .wdata_i(wdata), .wbyteen_i(wbyteen), .raddr_i(raddr), .rdata_o(rdata_z)
    );

    regfile_nport #(.WIDTH(32), .ADDR_BITS(5), .NREAD(2), .ZERO_REG(0)) dut_n (
        .clk_i(clk), .rst_i(rst), .wrenable_i(wrenable), .waddr_i(waddr),
        .wdata_i(wdata), .wbyteen_i(wbyteen), .raddr_i(raddr), .rdata_o(rdata_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          dut;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    function automatic logic [31:0] observed(input int dut, input int port);
        if (dut == 0) return rdata_z[port*32 +: 32];
        return rdata_n[port*32 +: 32];
    endfunction

    task automatic push(input string tag, input int dut, input int port, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.dut = dut; e.port = port; e.exp = exp;
        q.push_back(e);
    endtask

    // Same expectation on both ports of each instance.
    task automatic push4(input string tag, input logic [31:0] exp_z, input logic [31:0] exp_n);
        push(tag, 0, 0, exp_z);
        push(tag, 0, 1, exp_z);
        push(tag, 1, 0, exp_n);
        push(tag, 1, 1, exp_n);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = observed(e.dut, e.port);
            n_cmp++;
            assert (obs === e.exp) else begin
                n_mis++;
                $error("FAIL %s dut%0d port%0d: observed %h expected %h",
                       e.tag, e.dut, e.port, obs, e.exp);
            end
        end
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    // Drive a write after the falling edge, leaving it active for the next rising edge.
    task automatic drive_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        wrenable = 1'b1;
        waddr    = a;
        wdata    = d;
        wbyteen  = be;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
        wrenable = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        wrenable = 1'b0;
        waddr    = '0;
        wdata    = '0;
        wbyteen  = '0;
        raddr    = '0;

        // Reset rises between edges; outputs must clear with no clk edge.
        #2 rst = 1'b1;
        set_rd(5'd0, 5'd1);
        #1;
        push4("reset_a0_a1", 32'h0, 32'h0);
        drain();
        set_rd(5'd31, 5'd31);
        #0.5;
        push4("reset_a31", 32'h0, 32'h0);
        drain();

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Full-word write.
        drive_wr(5'd5, 32'hDEADBEEF, 4'b1111);
        after_edge();
        set_rd(5'd5, 5'd5);
        #1;
        push4("full_write", 32'hDEADBEEF, 32'hDEADBEEF);
        drain();

        // Byte-masked write merges with the stored word.
        drive_wr(5'd5, 32'h11223344, 4'b0101);
        after_edge();
        #1;
        push4("byte_mask", 32'hDE22BE44, 32'hDE22BE44);
        drain();

        // Strobe with an empty mask changes nothing.
        drive_wr(5'd5, 32'hFFFFFFFF, 4'b0000);
        after_edge();
        #1;
        push4("empty_mask", 32'hDE22BE44, 32'hDE22BE44);
        drain();

        // Entry 0: hardwired zero versus plain storage, before and after the edge.
        drive_wr(5'd0, 32'hFFFFFFFF, 4'b1111);
        set_rd(5'd0, 5'd0);
        #1;
        push4("zero_pre", 32'h0, BYP ? 32'hFFFFFFFF : 32'h0);
        drain();
        after_edge();
        #1;
        push4("zero_post", 32'h0, 32'hFFFFFFFF);
        drain();

        // Same-cycle read/write on entry 7, with port1 reading entry 5 meanwhile.
        drive_wr(5'd7, 32'h00000001, 4'b1111);
        after_edge();
        drive_wr(5'd7, 32'h00180001, 4'b1111);
        set_rd(5'd7, 5'd5);
        #1;
        push("rw_pre", 0, 0, BYP ? 32'h00180001 : 32'h00000001);
        push("rw_pre", 1, 0, BYP ? 32'h00180001 : 32'h00000001);
        push("rw_other", 0, 1, 32'hDE22BE44);
        push("rw_other", 1, 1, 32'hDE22BE44);
        drain();
        after_edge();
        #1;
        push("rw_post", 0, 0, 32'h00180001);
        push("rw_post", 1, 0, 32'h00180001);
        drain();

        // Write on an edge while reset is held: dropped, and everything cleared.
        drive_wr(5'd3, 32'hA5A5A5A5, 4'b1111);
        rst = 1'b1;
        set_rd(5'd3, 5'd7);
        #1;
        push4("rst_fwd_block", 32'h0, 32'h0);
        drain();
        @(posedge clk);
        #1;
        push4("rst_edge", 32'h0, 32'h0);
        drain();

        // Release reset with the write still held; it commits on the next edge.
        @(negedge clk);
        rst = 1'b0;
        set_rd(5'd3, 5'd3);
        #1;
        push4("rst_rel_pre", BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 32'hA5A5A5A5 : 32'h0);
        drain();
        after_edge();
        #1;
        push4("rst_rel_post", 32'hA5A5A5A5, 32'hA5A5A5A5);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_nport.md
# regfile_nport

Parametrised multi-port register file for the Lab3 CPU datapath. It generalises the single 32-bit enabled register into a 2^ADDR_BITS-entry array with NREAD independent combinational read ports, one clocked write port with byte enables, and an optional hardwired-zero entry 0. It sits between decode (read addresses) and write-back (write port). An optional write-to-read bypass is selected at compile time.

## Interface
- WIDTH, 32, data width in bits; must be a multiple of 8
- ADDR_BITS, 5, address width; depth = 2^ADDR_BITS entries
- NREAD, 2, number of read ports, 1..4
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is ordinary storage
- clk  input  1  single clock, rising-edge active
- reset  input  1  asynchronous, active-high; clears every entry to 0
- wrenable  input  1  write strobe, sampled on rising clk
- waddr  input  ADDR_BITS  write address
- wdata  input  WIDTH  write data
- wbyteen  input  WIDTH/8  per-byte write mask; bit i covers wdata[8i+7:8i]
- raddr  input  NREAD*ADDR_BITS  read addresses, port k at [k*ADDR_BITS +: ADDR_BITS]
- rdata  output  NREAD*WIDTH  read data, port k at [k*WIDTH +: WIDTH]

## Operation
- Storage: 2^ADDR_BITS x WIDTH flops.
- Write: on rising clk with reset low and wrenable high, each byte of entry waddr whose wbyteen bit is 1 takes the matching byte of wdata; other bytes hold.
- wrenable high with wbyteen all 0: no entry changes.
- ZERO_REG=1: writes to address 0 are discarded; rdata for raddr 0 is 0 in every cycle, including while a write targets 0 under bypass.
- Read: each port is combinational from raddr and storage; ports are fully independent, and any number of ports may read the same address.
- Reset asserted: all entries go to 0 immediately, without waiting for clk, so all rdata read 0. A write whose clk edge coincides with reset asserted is dropped. Entries stay 0 until the first edge with reset low.
- Reset deasserted mid-operation: normal writes resume on the next rising clk.
- No internal state besides storage; no handshake. Callers hold wrenable/waddr/wdata/wbyteen stable around the edge.

## Timing
- Write latency: data is visible on a non-bypassed read after the rising edge that commits it; combinational delay only after that edge.
- Read latency: zero cycles (combinational).
- Read-during-write to the same address in the same cycle:
  - without bypass, rdata shows the old value until the edge;
  - with bypass, see Configuration.
- Reset-to-output: asynchronous; rdata reaches 0 within combinational delay of reset rising.

## Configuration
- Macro REGFILE_NPORT_BYPASS_EN.
- Defined: when wrenable=1, reset=0 and raddr[k]==waddr (and waddr is non-zero when ZERO_REG=1), rdata[k] is the byte-wise merge of wdata (bytes with wbyteen=1) and the stored value (other bytes), in the same cycle before the edge. This gives write-first semantics for the single-cycle datapath.
- Undefined: no forwarding path; reads are always the stored value (read-old semantics).
- The write behaviour is identical either way.

## Structure
- A shared package or header, regfile_defs, holds:
  - default WIDTH/ADDR_BITS/NREAD constants;
  - the BYTES = WIDTH/8 derived constant;
  - the reset value (all zeros).
- One sub-module, regfile_readport: a single read port (mux plus optional bypass merge), instantiated NREAD times in a generate loop.
- The top level holds the storage array, byte-masked write logic and the zero-register gating.

## Test plan
- Reset then read: assert reset with clk idle. All NREAD ports at addresses 0, 1 and 31 read 32'h00000000 with no clk edge.
- Full write: write 32'hDEADBEEF to entry 5 with wbyteen=4'b1111. After the edge, port0 and port1 both at raddr 5 read 32'hDEADBEEF.
- Byte-masked write: entry 5 holds 32'hDEADBEEF; write 32'h11223344 with wbyteen=4'b0101. Entry 5 reads 32'hDE22BE44.
- Zero register: with ZERO_REG=1, write 32'hFFFFFFFF to address 0. Entry 0 still reads 0 on every port. Repeat with ZERO_REG=0: entry 0 reads 32'hFFFFFFFF.
- Same-cycle read/write: entry 7 holds 32'h00000001; write 32'h00180001 to entry 7 with raddr0=7 before the edge. Before the edge, rdata0 reads 32'h00000001 without REGFILE_NPORT_BYPASS_EN and 32'h00180001 with it. After the edge, both builds read 32'h00180001.
- Reset mid-operation: write 32'hA5A5A5A5 to entry 3 with reset asserted coincident with the edge. Entry 3 reads 0. Deassert reset and write again: entry 3 reads 32'hA5A5A5A5 after the next edge.
